// File: rtl/isp_dram_pkg.sv
// Shared types and constants for the ISP picture DMA master.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package isp_dram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B
    } state_t;

    localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam int         BEAT_BYTES     = 16;

    // Picture start address; the product is kept to 32 bits so it wraps mod 2^32.
    function automatic logic [31:0] pic_addr(input logic [31:0] base,
                                             input logic [3:0]  pic,
                                             input logic [31:0] pic_bytes);
        return base + ({28'd0, pic} * pic_bytes);
    endfunction

endpackage

// File: rtl/isp_dram_beat_cnt.sv
// Beat counter shared by the read-data and write-data phases of a burst.
// Latency: count updates one cycle after i_clr / i_inc.
// Backpressure: none; counts only when the owner signals a completed beat.
// Ports: clk, rst_n, i_clr (restart at 0), i_inc (one beat done), o_is_last (count == LAST).
module isp_dram_beat_cnt #(
    parameter int LAST = 191
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_is_last
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_clr) begin
            r_cnt <= 8'd0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_is_last = (r_cnt == 8'(LAST));

endmodule

// File: rtl/isp_dram_ctrl.sv
// AXI4 burst master: one picture read or write per request, issued as a single INCR burst.
// Latency: accept -> ar/awvalid next cycle; read beats reach rd_* one cycle after rvalid; done one cycle after last R / B.
// Backpressure: req_ready only in IDLE; AXI valids held until handshake; wr_data held by client until wr_take.
// Ports: clk/rst_n; req_* request in; rd_* read stream out; wr_data/wr_take write stream; done/err status;
//        aw*/w*/b*/ar*/r*_s_inf AXI master channels (id 4, addr 32, len 8, size 3, burst 2, data 128, resp 2).
// Build option: ISP_DRAM_RLAST_CHECK_EN checks rlast against the beat count and ends the burst on an early rlast.
module isp_dram_ctrl
    import isp_dram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int          PIC_BYTES = 3072,
    parameter logic [3:0]  AXI_ID    = 4'd0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_wr,
    input  logic [3:0]   req_pic_no,
    output logic         rd_valid,
    output logic [127:0] rd_data,
    output logic         rd_last,
    input  logic [127:0] wr_data,
    output logic         wr_take,
    output logic         done,
    output logic         err,
    output logic [3:0]   awid_s_inf,
    output logic [31:0]  awaddr_s_inf,
    output logic [7:0]   awlen_s_inf,
    output logic [2:0]   awsize_s_inf,
    output logic [1:0]   awburst_s_inf,
    output logic         awvalid_s_inf,
    input  logic         awready_s_inf,
    output logic [127:0] wdata_s_inf,
    output logic         wlast_s_inf,
    output logic         wvalid_s_inf,
    input  logic         wready_s_inf,
    input  logic [3:0]   bid_s_inf,
    input  logic [1:0]   bresp_s_inf,
    input  logic         bvalid_s_inf,
    output logic         bready_s_inf,
    output logic [3:0]   arid_s_inf,
    output logic [31:0]  araddr_s_inf,
    output logic [7:0]   arlen_s_inf,
    output logic [2:0]   arsize_s_inf,
    output logic [1:0]   arburst_s_inf,
    output logic         arvalid_s_inf,
    input  logic         arready_s_inf,
    input  logic [3:0]   rid_s_inf,
    input  logic [127:0] rdata_s_inf,
    input  logic [1:0]   rresp_s_inf,
    input  logic         rlast_s_inf,
    input  logic         rvalid_s_inf,
    output logic         rready_s_inf
);

    localparam int          BEATS        = PIC_BYTES / BEAT_BYTES;
    localparam logic [7:0]  LP_LEN       = 8'(BEATS - 1);
    localparam logic [31:0] LP_PIC_BYTES = 32'(PIC_BYTES);

    state_t         r_state, w_next;
    logic [31:0]    r_addr;
    logic           r_err, r_done, r_rd_valid, r_rd_last;
    logic [127:0]   r_rd_data;
    logic           w_accept, w_r_hs, w_w_hs, w_b_hs, w_is_last;
    logic           w_r_end, w_rlast_bad;
    logic           w_unused;

    // IDs are fixed and only one burst is ever outstanding, so response IDs carry no information.
    assign w_unused = &{1'b0, rid_s_inf, bid_s_inf, rlast_s_inf};

    assign w_accept = req_valid & req_ready;
    assign w_r_hs   = (r_state == ST_R) & rvalid_s_inf;
    assign w_w_hs   = (r_state == ST_W) & wready_s_inf;
    assign w_b_hs   = (r_state == ST_B) & bvalid_s_inf;

`ifdef ISP_DRAM_RLAST_CHECK_EN
    assign w_rlast_bad = w_r_hs & (rlast_s_inf != w_is_last);
    assign w_r_end     = w_r_hs & (w_is_last | rlast_s_inf);
`else
    assign w_rlast_bad = 1'b0;
    assign w_r_end     = w_r_hs & w_is_last;
`endif

    isp_dram_beat_cnt #(
        .LAST (BEATS - 1)
    ) u_beat_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_accept),
        .i_inc     (w_r_hs | w_w_hs),
        .o_is_last (w_is_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        req_ready     = 1'b0;
        arid_s_inf    = 4'd0;
        araddr_s_inf  = 32'd0;
        arlen_s_inf   = 8'd0;
        arsize_s_inf  = 3'd0;
        arburst_s_inf = 2'd0;
        arvalid_s_inf = 1'b0;
        rready_s_inf  = 1'b0;
        awid_s_inf    = 4'd0;
        awaddr_s_inf  = 32'd0;
        awlen_s_inf   = 8'd0;
        awsize_s_inf  = 3'd0;
        awburst_s_inf = 2'd0;
        awvalid_s_inf = 1'b0;
        wdata_s_inf   = 128'd0;
        wlast_s_inf   = 1'b0;
        wvalid_s_inf  = 1'b0;
        wr_take       = 1'b0;
        bready_s_inf  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Hold off for the done cycle so the next request lands strictly after it.
                req_ready = ~r_done;
                if (req_valid && !r_done) begin
                    w_next = req_wr ? ST_AW : ST_AR;
                end
            end
            ST_AR: begin
                arvalid_s_inf = 1'b1;
                arid_s_inf    = AXI_ID;
                araddr_s_inf  = r_addr;
                arlen_s_inf   = LP_LEN;
                arsize_s_inf  = AXI_SIZE_16B;
                arburst_s_inf = AXI_BURST_INCR;
                if (arready_s_inf) begin
                    w_next = ST_R;
                end
            end
            ST_R: begin
                rready_s_inf = 1'b1;
                if (w_r_end) begin
                    w_next = ST_IDLE;
                end
            end
            ST_AW: begin
                awvalid_s_inf = 1'b1;
                awid_s_inf    = AXI_ID;
                awaddr_s_inf  = r_addr;
                awlen_s_inf   = LP_LEN;
                awsize_s_inf  = AXI_SIZE_16B;
                awburst_s_inf = AXI_BURST_INCR;
                if (awready_s_inf) begin
                    w_next = ST_W;
                end
            end
            ST_W: begin
                wvalid_s_inf = 1'b1;
                wdata_s_inf  = wr_data;
                wlast_s_inf  = w_is_last;
                wr_take      = wready_s_inf;
                if (wready_s_inf && w_is_last) begin
                    w_next = ST_B;
                end
            end
            ST_B: begin
                bready_s_inf = 1'b1;
                if (bvalid_s_inf) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= 32'd0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_data  <= 128'd0;
        end else begin
            r_done     <= w_r_end | w_b_hs;
            r_rd_valid <= w_r_hs;
            r_rd_last  <= w_r_hs & w_is_last;
            if (w_r_hs) begin
                r_rd_data <= rdata_s_inf;
            end
            if (w_accept) begin
                r_addr <= pic_addr(BASE_ADDR, req_pic_no, LP_PIC_BYTES);
                r_err  <= 1'b0;
            end else if ((w_r_hs && ((rresp_s_inf != RESP_OKAY) || w_rlast_bad)) ||
                         (w_b_hs && (bresp_s_inf != RESP_OKAY))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign rd_last  = r_rd_last;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_isp_dram_ctrl.sv
// Bench for isp_dram_ctrl: AXI slave + client model, expected-response queues and a monitor.
module tb_isp_dram_ctrl;

    typedef struct packed { logic [127:0] d; logic l; logic dn; } rbeat_t;
    typedef struct packed { logic [127:0] d; logic l; } wbeat_t;

    logic         clk, rst_n;
    logic         req_valid, req_ready, req_wr;
    logic [3:0]   req_pic_no;
    logic         rd_valid, rd_last, wr_take, done, err;
    logic [127:0] rd_data, wr_data;
    logic [3:0]   awid, arid, bid, rid;
    logic [31:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst, bresp, rresp;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic [127:0] wdata, rdata;

    int n_chk = 0, n_fail = 0;
    int cfg_ar_dly = 0, cfg_aw_dly = 0, cfg_wmode = 0, cfg_rgap = 0;
    int cfg_rerr = -1, cfg_cut = -1;
    logic [1:0] cfg_bresp = 2'b00;
    logic [31:0] w_seed = 32'd0;
    int rd_cnt = 0;
    bit busy = 0;

    logic [31:0] q_ar[$], q_aw[$];
    rbeat_t      q_rd[$];
    wbeat_t      q_w[$];
    bit          q_done[$];

    isp_dram_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_pic_no(req_pic_no), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_last(rd_last), .wr_data(wr_data), .wr_take(wr_take), .done(done), .err(err),
        .awid_s_inf(awid), .awaddr_s_inf(awaddr), .awlen_s_inf(awlen), .awsize_s_inf(awsize),
        .awburst_s_inf(awburst), .awvalid_s_inf(awvalid), .awready_s_inf(awready),
        .wdata_s_inf(wdata), .wlast_s_inf(wlast), .wvalid_s_inf(wvalid), .wready_s_inf(wready),
        .bid_s_inf(bid), .bresp_s_inf(bresp), .bvalid_s_inf(bvalid), .bready_s_inf(bready),
        .arid_s_inf(arid), .araddr_s_inf(araddr), .arlen_s_inf(arlen), .arsize_s_inf(arsize),
        .arburst_s_inf(arburst), .arvalid_s_inf(arvalid), .arready_s_inf(arready),
        .rid_s_inf(rid), .rdata_s_inf(rdata), .rresp_s_inf(rresp), .rlast_s_inf(rlast),
        .rvalid_s_inf(rvalid), .rready_s_inf(rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [127:0] rfun(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_A5A5, a[15:0], a[31:16]};
    endfunction

    function automatic logic [127:0] wpat(input logic [31:0] s, input int i);
        return {s, 32'(i), s ^ 32'hDEAD_BEEF, ~32'(i)};
    endfunction

    function automatic logic [31:0] exp_addr(input logic [3:0] pic);
        return 32'h0001_0000 + 32'(pic) * 32'd3072;
    endfunction

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // AXI slave and write client: sample handshakes at negedge, react after posedge.
    initial begin
        bit s_ar, s_aw, s_r, s_w, s_b, s_rlast, rd_act, b_pend;
        logic [31:0] s_araddr, rd_addr;
        logic [7:0] s_arlen, s_awlen;
        int rd_beat, rd_tot, ar_wait, aw_wait, w_cnt, wr_tot, b_dly, w_idx;
        rd_act = 0; b_pend = 0; rd_beat = 0; rd_tot = 0; ar_wait = 0; aw_wait = 0;
        w_cnt = 0; wr_tot = 0; b_dly = 0; w_idx = 0; rd_addr = 0;
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0; rlast = 0;
        rdata = 0; rresp = 0; bresp = 0; rid = 0; bid = 0; wr_data = 0;
        forever begin
            @(negedge clk);
            s_ar = arvalid & arready; s_aw = awvalid & awready; s_r = rvalid & rready;
            s_w = wvalid & wready; s_b = bvalid & bready; s_rlast = rlast;
            s_araddr = araddr; s_arlen = arlen; s_awlen = awlen;
            @(posedge clk); #1;
            if (!rst_n) begin
                rd_act = 0; b_pend = 0; ar_wait = 0; aw_wait = 0;
                arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
                rlast = 0; rdata = 0; rresp = 0; bresp = 0;
            end else begin
                if (s_ar) begin
                    rd_act = 1; rd_addr = s_araddr; rd_beat = 0; rd_tot = int'(s_arlen) + 1;
                end
                if (s_r) begin
                    rd_beat++;
                    if (rd_beat == rd_tot || s_rlast) rd_act = 0;
                end
                if (s_aw) begin
                    w_cnt = 0; wr_tot = int'(s_awlen) + 1; w_idx = 0;
                end
                if (s_w) begin
                    w_idx++; w_cnt++;
                    if (w_cnt == wr_tot) begin b_pend = 1; b_dly = int'($urandom_range(2)); end
                end
                wr_data = wpat(w_seed, w_idx);
                if (arvalid) begin
                    if (ar_wait >= cfg_ar_dly) arready = 1;
                    else begin arready = 0; ar_wait++; end
                end else begin
                    arready = 0; ar_wait = 0;
                end
                if (awvalid) begin
                    if (aw_wait >= cfg_aw_dly) awready = 1;
                    else begin awready = 0; aw_wait++; end
                end else begin
                    awready = 0; aw_wait = 0;
                end
                if (rd_act && (cfg_rgap == 0 || $urandom_range(3) != 0)) begin
                    rvalid = 1;
                    rdata  = rfun(rd_addr + 32'(rd_beat * 16));
                    rlast  = (rd_beat == rd_tot - 1) || (rd_beat == cfg_cut);
                    rresp  = (rd_beat == cfg_rerr) ? 2'b10 : 2'b00;
                end else begin
                    rvalid = 0; rlast = 0; rresp = 0;
                end
                if (cfg_wmode == 0) wready = 1;
                else if (cfg_wmode == 1) wready = ~wready;
                else wready = 1'($urandom_range(1));
                if (s_b) begin
                    bvalid = 0; b_pend = 0; bresp = 0;
                end else if (b_pend) begin
                    if (b_dly == 0) begin bvalid = 1; bresp = cfg_bresp; end
                    else b_dly--;
                end
            end
        end
    end

    // Monitor: pops expected responses whenever the DUT presents one.
    initial begin
        bit p_ar_wait, p_aw_wait, p_r_hs, p_b_hs, p_acc, e;
        logic [31:0] p_araddr, p_awaddr, ea;
        logic [7:0] p_arlen, p_awlen;
        rbeat_t rb; wbeat_t wb;
        p_ar_wait = 0; p_aw_wait = 0; p_r_hs = 0; p_b_hs = 0; p_acc = 0;
        p_araddr = 0; p_awaddr = 0; p_arlen = 0; p_awlen = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_ar_wait = 0; p_aw_wait = 0; p_r_hs = 0; p_b_hs = 0; p_acc = 0;
            end else begin
                if (p_acc) chk("addr_valid_after_accept", 160'(arvalid | awvalid), 160'(1));
                p_acc = req_valid & req_ready;
                if (p_acc) begin chk("accept_while_busy", 160'(busy), 160'(0)); busy = 1; end
                if (p_ar_wait) chk("ar_stable", {arvalid, araddr, arlen}, {1'b1, p_araddr, p_arlen});
                if (p_aw_wait) chk("aw_stable", {awvalid, awaddr, awlen}, {1'b1, p_awaddr, p_awlen});
                p_ar_wait = arvalid & ~arready; p_araddr = araddr; p_arlen = arlen;
                p_aw_wait = awvalid & ~awready; p_awaddr = awaddr; p_awlen = awlen;
                if (arvalid & arready) begin
                    if (q_ar.size() == 0) chk("ar_unexpected", 160'(1), 160'(0));
                    else begin
                        ea = q_ar.pop_front();
                        chk("ar_addr", 160'(araddr), 160'(ea));
                        chk("ar_ctrl", {arid, arlen, arsize, arburst}, {4'd0, 8'd191, 3'd4, 2'd1});
                    end
                end
                if (awvalid & awready) begin
                    if (q_aw.size() == 0) chk("aw_unexpected", 160'(1), 160'(0));
                    else begin
                        ea = q_aw.pop_front();
                        chk("aw_addr", 160'(awaddr), 160'(ea));
                        chk("aw_ctrl", {awid, awlen, awsize, awburst}, {4'd0, 8'd191, 3'd4, 2'd1});
                    end
                end
                if (rd_valid | p_r_hs) chk("rd_latency", 160'(rd_valid), 160'(p_r_hs));
                p_r_hs = rvalid & rready;
                if (rd_valid) begin
                    rd_cnt++;
                    if (q_rd.size() == 0) chk("rd_unexpected", 160'(1), 160'(0));
                    else begin
                        rb = q_rd.pop_front();
                        chk("rd_beat", {rd_data, rd_last, done}, {rb.d, rb.l, rb.dn});
                    end
                end
                if (wr_take | (wvalid & wready)) begin
                    chk("wr_take", 160'(wr_take), 160'(wvalid & wready));
                    if (q_w.size() == 0) chk("w_unexpected", 160'(1), 160'(0));
                    else begin
                        wb = q_w.pop_front();
                        chk("w_beat", {wdata, wlast}, {wb.d, wb.l});
                    end
                end
                if (p_b_hs) chk("done_after_b", 160'(done), 160'(1));
                p_b_hs = bvalid & bready;
                if (done) begin
                    if (q_done.size() == 0) chk("done_unexpected", 160'(1), 160'(0));
                    else begin
                        e = q_done.pop_front();
                        chk("err_at_done", 160'(err), 160'(e));
                    end
                    busy = 0;
                end
            end
        end
    end

    task automatic push_read(input logic [31:0] a, input int n);
        rbeat_t rb;
        q_ar.push_back(a);
        for (int i = 0; i < n; i++) begin
            rb.d = rfun(a + 32'(i * 16)); rb.l = (i == 191); rb.dn = (i == n - 1);
            q_rd.push_back(rb);
        end
    endtask

    task automatic wait_accept();
        bit got = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (req_ready) got = 1;
        end
        if (!got) chk("accept_timeout", 160'(0), 160'(1));
        @(posedge clk); #1;
        chk("err_clear_at_accept", 160'(err), 160'(0));
    endtask

    task automatic do_req(input bit wr, input logic [3:0] pic, input bit keep);
        logic [31:0] a;
        int n;
        bit e, got;
        wbeat_t wb;
        a = exp_addr(pic);
        if (wr) begin
            w_seed = $urandom;
            q_aw.push_back(a);
            for (int i = 0; i < 192; i++) begin
                wb.d = wpat(w_seed, i); wb.l = (i == 191);
                q_w.push_back(wb);
            end
            e = (cfg_bresp != 2'b00);
        end else begin
            n = (cfg_cut >= 0) ? cfg_cut + 1 : 192;
            push_read(a, n);
            e = (cfg_cut >= 0) || (cfg_rerr >= 0 && cfg_rerr < n);
        end
        q_done.push_back(e);
        req_wr = wr; req_pic_no = pic; req_valid = 1'b1;
        wait_accept();
        if (!keep) req_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        if (!got) chk("done_timeout", 160'(0), 160'(1));
        @(posedge clk); #1;
        chk("req_ready_after_done", 160'(req_ready), 160'(1));
        chk("queues_drained", 160'(q_rd.size() + q_w.size()), 160'(0));
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk(nm, {req_ready, rd_valid, rd_last, done, err, wr_take, arvalid, rready,
                 awvalid, wvalid, wlast, bready}, 160'h800);
        chk({nm, "_bus"}, 160'(|{rd_data, araddr, arlen, arsize, arburst, arid,
                               awaddr, awlen, awsize, awburst, awid, wdata}), 160'(0));
    endtask

    initial begin
        bit got;
        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_pic_no = 4'd0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset_values");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Read pic 3, zero wait states.
        do_req(1'b0, 4'd3, 1'b0);
        // Write pic 0, wready toggling.
        cfg_wmode = 1;
        do_req(1'b1, 4'd0, 1'b0);
        // Write with SLVERR, then a clean read clears err.
        cfg_bresp = 2'b10; cfg_wmode = 2;
        do_req(1'b1, 4'($urandom_range(15)), 1'b0);
        chk("err_after_bresp", 160'(err), 160'(1));
        cfg_bresp = 2'b00; cfg_rgap = 1;
        do_req(1'b0, 4'($urandom_range(15)), 1'b0);
        chk("err_after_clean_read", 160'(err), 160'(0));
        // Slow arready with req_valid held across two requests.
        cfg_ar_dly = 5; cfg_rgap = 0;
        do_req(1'b0, 4'd7, 1'b1);
        cfg_ar_dly = 0; cfg_aw_dly = 3;
        do_req(1'b1, 4'd9, 1'b0);
        // Randomised mix.
        for (int k = 0; k < 6; k++) begin
            cfg_ar_dly = int'($urandom_range(3)); cfg_aw_dly = int'($urandom_range(3));
            cfg_wmode = int'($urandom_range(2)); cfg_rgap = int'($urandom_range(1));
            do_req(1'($urandom_range(1)), 4'($urandom_range(15)), 1'b0);
        end
        // Read with an error response on one beat.
        cfg_rerr = int'($urandom_range(191));
        do_req(1'b0, 4'($urandom_range(15)), 1'b0);
        chk("err_after_rresp", 160'(err), 160'(1));
        cfg_rerr = -1; cfg_rgap = 0; cfg_ar_dly = 0;

        // Reset in the middle of a read burst.
        rd_cnt = 0;
        push_read(exp_addr(4'd5), 192);
        q_done.push_back(1'b0);
        req_wr = 1'b0; req_pic_no = 4'd5; req_valid = 1'b1;
        wait_accept();
        req_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 1000 && !got; c++) begin
            @(negedge clk); #1;
            if (rd_cnt >= 50) got = 1;
        end
        if (!got) chk("beat50_timeout", 160'(0), 160'(1));
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        q_ar.delete(); q_rd.delete(); q_done.delete(); busy = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, 4'd15, 1'b0);

`ifdef ISP_DRAM_RLAST_CHECK_EN
        // Early rlast on beat 100 ends the burst with err.
        cfg_cut = 100;
        do_req(1'b0, 4'($urandom_range(15)), 1'b0);
        chk("err_after_early_rlast", 160'(err), 160'(1));
        chk("idle_after_early_rlast", 160'(req_ready), 160'(1));
        cfg_cut = -1;
`endif

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/isp_dram_ctrl.md
# isp_dram_ctrl

AXI4 burst master that moves whole pictures between the ISP core and the pseudo-DRAM. It accepts one picture-level read or write request at a time and converts it into a single INCR burst. It sequences the address, data and response channels, and streams 128-bit beats to or from the ISP datapath. It sits between the ISP core logic and the `*_s_inf` AXI ports of ISP.

## Interface
Parameters:
- BASE_ADDR, 32'h0001_0000, byte address of picture 0
- PIC_BYTES, 3072, bytes per picture; must be a multiple of 16; BEATS = PIC_BYTES/16 (192 by default)
- AXI_ID, 4'd0, value driven on awid_s_inf and arid_s_inf

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request strobe
- req_ready  out  1  high only in IDLE
- req_wr  in  1  1 = write picture to DRAM, 0 = read
- req_pic_no  in  4  picture index
- rd_valid  out  1  read beat valid
- rd_data  out  128  read beat data
- rd_last  out  1  final read beat
- wr_data  in  128  write beat; client holds it until wr_take
- wr_take  out  1  current wr_data consumed this cycle
- done  out  1  one-cycle pulse when the request completes
- err  out  1  sticky error flag; cleared on next accepted request
- All AXI write-address, write-data, write-response, read-address and read-data channel ports (`awid_s_inf` … `rready_s_inf`), with the widths used by ISP: id 4, addr 32, len 8, size 3, burst 2, data 128, resp 2.

## Operation
- FSM states: IDLE, AR, R, AW, W, B.
- Acceptance: a request is accepted when req_valid & req_ready in IDLE.
- Latched on acceptance: addr = BASE_ADDR + req_pic_no*PIC_BYTES (32-bit, wraps mod 2^32), req_wr, beat counter = 0, err = 0.
- Next state after acceptance: AR if req_wr = 0, AW if req_wr = 1.
- AR: arvalid = 1 with araddr = addr, arlen = BEATS-1, arsize = 3'b100, arburst = 2'b01.
  - araddr and arlen stay stable until arready; then go to R.
- R: rready = 1.
  - Each rvalid beat is registered to rd_valid/rd_data on the next cycle; counter increments.
  - rd_last = 1 on beat BEATS-1.
  - rresp ≠ 0 on any beat sets err.
  - After beat BEATS-1 is accepted: done pulses together with rd_last, then IDLE.
- AW: same handshake rules as AR, on the aw* channel. Then go to W.
- W: wvalid = 1, wdata = wr_data (combinational), wlast = (counter == BEATS-1).
  - wr_take = wvalid & wready.
  - After the last accepted beat, go to B.
- B: bready = 1. On bvalid: err |= (bresp ≠ 0), done pulses next cycle, then IDLE.
- Outputs in R/W: valid signals are never deasserted before their handshake. Idle-channel outputs are driven to 0.
- A rvalid outside R, or a bvalid outside B, is ignored.

## Timing
- Reset values: all outputs 0 except req_ready = 1. FSM = IDLE, counter = 0, err = 0.
- Reset mid-burst abandons the transaction immediately; no AXI cleanup.
- Minimum latency, read: accept → arvalid next cycle → first rd_valid 1 cycle after the first rvalid handshake.
- Write: the first wr_take can occur in the cycle after the awready handshake.
- done is asserted for exactly one cycle per request. req_ready returns the cycle after done.
- Back-to-back requests: the earliest next acceptance is the cycle after done.

## Configuration
- ISP_DRAM_RLAST_CHECK_EN
  - Defined: in R, rlast must equal (counter == BEATS-1). Any mismatch sets err. A premature rlast also ends the burst: done pulses and the FSM returns to IDLE.
  - Undefined: rlast is ignored, and termination is purely count-based.

## Structure
- Package isp_dram_pkg:
  - state enum
  - AXI_SIZE_16B = 3'b100
  - AXI_BURST_INCR = 2'b01
  - RESP_OKAY = 2'b00
  - BEAT_BYTES = 16
- One sub-module, isp_dram_beat_cnt: 8-bit counter with clear, increment and is_last outputs, shared by the R and W states.

## Test plan
- Read, pic 3, slave with zero wait states:
  - araddr = 0x0001_2400, arlen = 191, arsize = 4, arburst = 1.
  - 192 rd_valid beats with matching data; rd_last and done on beat 191; err = 0.
- Write, pic 0, wready toggling every other cycle:
  - awaddr = 0x0001_0000.
  - 192 wr_take pulses; wlast only on the 192nd.
  - done pulses 1 cycle after bvalid.
- Write with bresp = 2'b10 → err = 1 after done. The next read request clears err to 0 at acceptance.
- arready delayed 5 cycles → araddr/arlen stable for all 6 cycles. req_valid held during the burst → not accepted until IDLE.
- rst_n asserted at read beat 50 → all outputs at reset values asynchronously. A new read of pic 15 then gives araddr = 0x0001_B400.
- With ISP_DRAM_RLAST_CHECK_EN, slave asserts rlast on beat 100 → err = 1, done on beat 100, FSM back in IDLE.
